// File: rtl/trivium_pkg.sv
// Shared types and constants for the Trivium sequencing controller.
// Holds the FSM state encoding and the key/IV/warm-up sizing.
package trivium_pkg;

  localparam int KEY_W = 80;
  localparam int IV_W  = 80;

  // Four full rotations of the 288-bit Trivium state.
  localparam int WARMUP_DEFAULT = 4 * 288;

  typedef enum logic [2:0] {
    S_LOAD,
    S_CORELOAD,
    S_WARMUP,
    S_IDLE,
    S_GEN,
    S_TX
  } state_e;

endpackage

// File: rtl/byte_hold.sv
// One-entry byte buffer used to park a received byte while busy.
// A push into a full entry without a same-cycle pop is reported on drop_o.
module byte_hold (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       drop_o
);

  logic       full_q, full_d;
  logic [7:0] data_q, data_d;

  // Next entry state: clear wins, a pop frees the slot for a same-cycle push.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clr_i) begin
      full_d = 1'b0;
    end else begin
      if (pop_i) begin
        full_d = 1'b0;
      end
      if (push_i && (!full_q || pop_i)) begin
        full_d = 1'b1;
        data_d = din_i;
      end
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= 8'h00;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign dout_o = data_q;
  assign full_o = full_q;
  assign drop_o = push_i && full_q && !pop_i && !clr_i;

endmodule

// File: rtl/trivium_ctrl.sv
// Sequencer for the Trivium core: key/IV collection, load, warm-up,
// then per-byte keystream generation and hand-off to the transmitter.
module trivium_ctrl
  import trivium_pkg::*;
#(
  parameter int WARMUP_CYCLES = WARMUP_DEFAULT,
  parameter int KEY_BYTES     = KEY_W / 8,
  parameter int IV_BYTES      = IV_W / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rekey,
  output logic [KEY_W-1:0] core_key,
  output logic [IV_W-1:0]  core_iv,
  output logic             core_load,
  output logic             core_en,
  input  logic             core_ks,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             enc_done,
  output logic             overflow
);

  localparam int WW   = $clog2(WARMUP_CYCLES + 1);
  localparam int LAST = KEY_BYTES + IV_BYTES - 1;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WW-1:0]    warm_q, warm_d;
  logic [2:0]       gen_q, gen_d;
  logic [7:0]       ks_q, ks_d;
  logic [7:0]       pt_q, pt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [IV_W-1:0]  iv_q, iv_d;
  logic             ovf_q;

  logic       h_push;
  logic       h_pop;
  logic [7:0] h_dout;
  logic       h_full;
  logic       h_drop;

  byte_hold u_hold (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (rekey),
    .push_i (h_push),
    .pop_i  (h_pop),
    .din_i  (rx_data),
    .dout_o (h_dout),
    .full_o (h_full),
    .drop_o (h_drop)
  );

  // Next-state, counters, key/IV capture and hold-buffer control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    warm_d  = warm_q;
    gen_d   = gen_q;
    ks_d    = ks_q;
    pt_d    = pt_q;
    key_d   = key_q;
    iv_d    = iv_q;
    h_push  = 1'b0;
    h_pop   = 1'b0;
    if (rekey) begin
      state_d = S_LOAD;
      cnt_d   = 5'd0;
      warm_d  = '0;
      gen_d   = 3'd0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (rx_valid) begin
            for (int i = 0; i < KEY_BYTES; i++) begin
              if (cnt_q == 5'(i)) key_d[8*i +: 8] = rx_data;
            end
            for (int i = 0; i < IV_BYTES; i++) begin
              if (cnt_q == 5'(KEY_BYTES + i)) iv_d[8*i +: 8] = rx_data;
            end
            if (cnt_q == 5'(LAST)) begin
              state_d = S_CORELOAD;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
        S_CORELOAD: begin
          h_push  = rx_valid;
          warm_d  = '0;
          state_d = S_WARMUP;
        end
        S_WARMUP: begin
          h_push = rx_valid;
          if (warm_q == WW'(WARMUP_CYCLES - 1)) begin
            warm_d  = '0;
            state_d = S_IDLE;
          end else begin
            warm_d = warm_q + 1'b1;
          end
        end
        S_IDLE: begin
          gen_d = 3'd0;
          if (h_full) begin
            h_pop   = 1'b1;
            h_push  = rx_valid;
            pt_d    = h_dout;
            state_d = S_GEN;
          end else if (rx_valid) begin
            pt_d    = rx_data;
            state_d = S_GEN;
          end
        end
        S_GEN: begin
          h_push      = rx_valid;
          ks_d[gen_q] = core_ks;
          if (gen_q == 3'd7) begin
            gen_d   = 3'd0;
            state_d = S_TX;
          end else begin
            gen_d = gen_q + 3'd1;
          end
        end
        S_TX: begin
          h_push = rx_valid;
          if (tx_ready) begin
            if (h_full) begin
              h_pop   = 1'b1;
              pt_d    = h_dout;
              gen_d   = 3'd0;
              state_d = S_GEN;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= 5'd0;
      warm_q  <= '0;
      gen_q   <= 3'd0;
      ks_q    <= 8'h00;
      pt_q    <= 8'h00;
      key_q   <= '0;
      iv_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
      gen_q   <= gen_d;
      ks_q    <= ks_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      iv_q    <= iv_d;
    end
  end

  // Sticky drop flag, cleared only by rekey or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (rekey) begin
      ovf_q <= 1'b0;
    end else if (h_drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign core_key  = key_q;
  assign core_iv   = iv_q;
  assign core_load = (state_q == S_CORELOAD);
  assign core_en   = (state_q == S_WARMUP) || (state_q == S_GEN);
  assign enc_done  = (state_q == S_IDLE);
  assign tx_valid  = (state_q == S_TX);
  assign tx_data   = (state_q == S_TX) ? (pt_q ^ ks_q) : 8'h00;
  assign overflow  = ovf_q;

endmodule
